sreg_tx: RTL and testbench



---
 rtl/sreg_tx_pkg.sv | 23 ++
 rtl/sreg_tx_tick.sv | 30 +++
 rtl/sreg_tx.sv | 134 +++++++++++++
 tb/tb_sreg_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sreg_tx_pkg.sv
// sreg_tx_pkg: shared types and constants for the serial-load transmitter.
//   state_t    - transmitter FSM states
//   *_DEF      - default word width / clock divider
//   cnt_w()    - width of a counter that must hold values below n
package sreg_tx_pkg;

  localparam int DWIDTH_DEF = 21;
  localparam int CLKDIV_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    TAIL
  } state_t;

  // $clog2 of n, but never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sreg_tx_tick.sv
// sreg_tx_tick: phase counter for the shift clock.
//   clk, reset - system clock, async active-high reset
//   i_en       - count while high; counter is held at zero when low
//   o_tick     - one-cycle pulse on the last cycle of each CLKDIV-cycle phase
module sreg_tx_tick
  import sreg_tx_pkg::*;
#(
  parameter int CLKDIV = CLKDIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_tick
);

  localparam int            CW   = cnt_w(CLKDIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKDIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  // wrap on tick so each new phase starts from zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               r_cnt <= '0;
    else if (!i_en || o_tick) r_cnt <= '0;
    else                     r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/sreg_tx.sv
// sreg_tx: parallel-in, serial-out transmitter for the CPLD serial-load link.
//   clk, reset - system clock, async active-high reset
//   i_data     - parallel word, sampled on the accepting edge
//   i_load     - transmit request; accepted when o_ready is high
//   o_ready    - idle / can accept
//   o_sclk     - shift clock (receiver samples o_sdo on its rising edge)
//   o_sdo      - serial data, MSB first
//   o_sen_n    - frame enable, low for the whole transfer
//   o_done     - one-cycle pulse on completion
// All outputs come straight from flops so sclk/sen_n are glitch-free.
module sreg_tx
  import sreg_tx_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int CLKDIV = CLKDIV_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_load,
  output logic              o_ready,
  output logic              o_sclk,
  output logic              o_sdo,
  output logic              o_sen_n,
  output logic              o_done
);

  localparam int            BW       = cnt_w(DWIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DWIDTH - 1);

  state_t            r_state, w_state;
  logic [DWIDTH-1:0] r_shreg, w_shreg;
  logic [BW-1:0]     r_bitcnt, w_bitcnt;
  logic              r_ready, w_ready;
  logic              r_sclk, w_sclk;
  logic              r_sdo, w_sdo;
  logic              r_sen_n, w_sen_n;
  logic              r_done, w_done;
  logic              w_tick;

  sreg_tx_tick #(.CLKDIV(CLKDIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .i_en  (r_state != IDLE),
    .o_tick(w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_ready  <= 1'b1;
      r_sclk   <= 1'b0;
      r_sdo    <= 1'b0;
      r_sen_n  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_shreg  <= w_shreg;
      r_bitcnt <= w_bitcnt;
      r_ready  <= w_ready;
      r_sclk   <= w_sclk;
      r_sdo    <= w_sdo;
      r_sen_n  <= w_sen_n;
      r_done   <= w_done;
    end
  end

  // next-state logic computes next output values, so every output is a flop
  always_comb begin
    w_state  = r_state;
    w_shreg  = r_shreg;
    w_bitcnt = r_bitcnt;
    w_ready  = r_ready;
    w_sclk   = r_sclk;
    w_sdo    = r_sdo;
    w_sen_n  = r_sen_n;
    w_done   = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        w_sclk  = 1'b0;
        w_sdo   = 1'b0;
        w_sen_n = 1'b1;
        if (i_load) begin
          w_state  = SETUP;
          w_shreg  = i_data;
          w_bitcnt = LAST_BIT;
          w_ready  = 1'b0;
          w_sen_n  = 1'b0;
          w_sdo    = i_data[DWIDTH-1];
        end
      end
      SETUP, LOW: begin
        if (w_tick) begin
          w_state = HIGH;
          w_sclk  = 1'b1;
        end
      end
      HIGH: begin
        if (w_tick) begin
          w_sclk = 1'b0;
          if (r_bitcnt == '0) begin
            w_state = TAIL;
          end else begin
            // next bit goes out on the falling edge, a full phase before the rise
            w_state  = LOW;
            w_shreg  = {r_shreg[DWIDTH-2:0], 1'b0};
            w_bitcnt = r_bitcnt - 1'b1;
            w_sdo    = r_shreg[DWIDTH-2];
          end
        end
      end
      TAIL: begin
        if (w_tick) begin
          w_state = IDLE;
          w_ready = 1'b1;
          w_sen_n = 1'b1;
          w_sdo   = 1'b0;
          w_done  = 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign o_ready = r_ready;
  assign o_sclk  = r_sclk;
  assign o_sdo   = r_sdo;
  assign o_sen_n = r_sen_n;
  assign o_done  = r_done;

endmodule

// File: tb/tb_sreg_tx.sv
module tb_sreg_tx;

  localparam int DA = 21, CA = 4;   // default instance
  localparam int DB = 8,  CB = 1;   // fast instance

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic [DA-1:0] a_data = '0;
  logic a_load = 1'b0, a_ready, a_sclk, a_sdo, a_sen_n, a_done;
  logic [DB-1:0] b_data = '0;
  logic b_load = 1'b0, b_ready, b_sclk, b_sdo, b_sen_n, b_done;

  sreg_tx dut (
    .clk(clk), .reset(reset), .i_data(a_data), .i_load(a_load),
    .o_ready(a_ready), .o_sclk(a_sclk), .o_sdo(a_sdo), .o_sen_n(a_sen_n), .o_done(a_done));

  sreg_tx #(.DWIDTH(DB), .CLKDIV(CB)) dut8 (
    .clk(clk), .reset(reset), .i_data(b_data), .i_load(b_load),
    .o_ready(b_ready), .o_sclk(b_sclk), .o_sdo(b_sdo), .o_sen_n(b_sen_n), .o_done(b_done));

  int n_cmp = 0, n_err = 0;

  // Loopback receivers: left-shift sdo on each sclk rise, plus link-timing checks
  logic [63:0] a_rx = '0, b_rx = '0;
  int a_rises = 0, a_perr = 0, a_serr = 0, a_herr = 0, a_t = 0, a_lr = 0, a_age = 0, a_hi = 0;
  int a_gap = 0, a_last_gap = 0;
  int b_rises = 0, b_perr = 0, b_serr = 0, b_herr = 0, b_t = 0, b_lr = 0, b_age = 0, b_hi = 0;
  logic a_ps = 0, a_pd = 0, a_first = 0, b_ps = 0, b_pd = 0, b_first = 0;

  always @(negedge clk) begin
    a_t++;
    if (a_sdo !== a_pd) a_age = 0; else a_age++;
    if (a_sclk && !a_ps) begin
      if (a_rises == 0) a_first = a_sdo;
      else if (a_t - a_lr != 2*CA) a_perr++;
      if (a_age < CA) a_serr++;
      a_rx = {a_rx[62:0], a_sdo}; a_rises++; a_lr = a_t;
    end
    if (a_sclk && a_ps && a_sdo !== a_pd) a_herr++;
    if (!a_sclk && a_ps && a_hi != CA) a_perr++;
    a_hi = a_sclk ? a_hi + 1 : 0;
    if (a_sen_n) a_gap++;
    else begin if (a_gap > 0) a_last_gap = a_gap; a_gap = 0; end
    a_ps = a_sclk; a_pd = a_sdo;
  end

  always @(negedge clk) begin
    b_t++;
    if (b_sdo !== b_pd) b_age = 0; else b_age++;
    if (b_sclk && !b_ps) begin
      if (b_rises == 0) b_first = b_sdo;
      else if (b_t - b_lr != 2*CB) b_perr++;
      if (b_age < CB) b_serr++;
      b_rx = {b_rx[62:0], b_sdo}; b_rises++; b_lr = b_t;
    end
    if (b_sclk && b_ps && b_sdo !== b_pd) b_herr++;
    if (!b_sclk && b_ps && b_hi != CB) b_perr++;
    b_hi = b_sclk ? b_hi + 1 : 0;
    b_ps = b_sclk; b_pd = b_sdo;
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  // Send one word; expectations follow from D and C alone:
  // sen_n low in cycle 0, first sclk rise in cycle C, D rises, done in cycle (2D+1)C.
  task automatic xfer(input string nm, input bit sel, input logic [20:0] w,
                      input bit hold, input int poke, input logic [20:0] pw);
    int D, C, dcyc, first_hi, busy, errs;
    logic [20:0] m, got;
    logic rdy, dn, sn, sc, fb;
    D = sel ? DB : DA; C = sel ? CB : CA;
    m = sel ? 21'h0000FF : 21'h1FFFFF;
    dcyc = -1; first_hi = -1; busy = 0;
    rdy = sel ? b_ready : a_ready;
    n_cmp++;
    if (rdy !== 1'b1) begin n_err++; $display("FAIL %s ready_before got=%b want=1", nm, rdy); end
    if (sel) begin
      b_data = w[7:0]; b_load = 1; b_rx = '0; b_rises = 0; b_perr = 0; b_serr = 0; b_herr = 0;
    end else begin
      a_data = w; a_load = 1; a_rx = '0; a_rises = 0; a_perr = 0; a_serr = 0; a_herr = 0;
    end
    @(posedge clk); #1;
    // data scrambled after acceptance must not matter
    if (sel) begin b_load = hold; b_data = 8'($urandom); end
    else     begin a_load = hold; a_data = 21'($urandom); end
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk); #1;
      if (!sel && c == poke) begin a_load = 1; a_data = pw; end
      else if (!sel && c == poke + 1) a_load = hold;
      rdy = sel ? b_ready : a_ready; dn = sel ? b_done : a_done;
      sn  = sel ? b_sen_n : a_sen_n; sc = sel ? b_sclk : a_sclk;
      if (c == 0) begin
        n_cmp++;
        if (sn !== 1'b0 || rdy !== 1'b0) begin
          n_err++; $display("FAIL %s accept_cycle sen_n=%b ready=%b want 0/0", nm, sn, rdy);
        end
      end
      if (sc === 1'b1 && first_hi < 0) first_hi = c;
      if (dn === 1'b1) begin dcyc = c; break; end
      if (rdy !== 1'b0) busy = 1;
    end
    got = (sel ? b_rx[20:0] : a_rx[20:0]) & m;
    fb  = sel ? b_first : a_first;
    errs = sel ? (b_perr + b_serr + b_herr) : (a_perr + a_serr + a_herr);
    n_cmp++;
    if (dcyc != (2*D+1)*C) begin n_err++; $display("FAIL %s done_cycle got=%0d want=%0d", nm, dcyc, (2*D+1)*C); end
    n_cmp++;
    if (first_hi != C) begin n_err++; $display("FAIL %s first_rise got=%0d want=%0d", nm, first_hi, C); end
    n_cmp++;
    if ((sel ? b_rises : a_rises) != D) begin
      n_err++; $display("FAIL %s rises got=%0d want=%0d", nm, sel ? b_rises : a_rises, D);
    end
    n_cmp++;
    if (got !== (w & m)) begin n_err++; $display("FAIL %s word got=%h want=%h", nm, got, w & m); end
    n_cmp++;
    if (fb !== w[D-1]) begin n_err++; $display("FAIL %s first_bit got=%b want=%b", nm, fb, w[D-1]); end
    n_cmp++;
    if (errs != 0) begin n_err++; $display("FAIL %s link_timing got=%0d violations want=0", nm, errs); end
    n_cmp++;
    if (busy != 0) begin n_err++; $display("FAIL %s ready_during_frame got=1 want=0", nm); end
    if (!hold) begin
      step();
      rdy = sel ? b_ready : a_ready; dn = sel ? b_done : a_done;
      sn  = sel ? b_sen_n : a_sen_n; sc = sel ? b_sclk : a_sclk;
      n_cmp++;
      if ({rdy, dn, sn, sc, (sel ? b_sdo : a_sdo)} !== 5'b10100) begin
        n_err++; $display("FAIL %s after_done rdy/done/sen_n/sclk/sdo got=%b want=10100", nm,
                          {rdy, dn, sn, sc, (sel ? b_sdo : a_sdo)});
      end
    end
  endtask

  task automatic test_reset();
    int sn_hi;
    reset = 1; repeat (3) step();
    reset = 0; step();
    n_cmp++;
    if ({a_ready, a_sen_n, a_sclk, a_sdo, a_done} !== 5'b11000) begin
      n_err++; $display("FAIL reset_state got=%b want=11000", {a_ready, a_sen_n, a_sclk, a_sdo, a_done});
    end
    a_rises = 0; b_rises = 0; sn_hi = 0;
    repeat (100) begin step(); if (a_sen_n === 1'b1 && b_sen_n === 1'b1) sn_hi++; end
    n_cmp++;
    if (a_rises != 0 || b_rises != 0 || sn_hi != 100) begin
      n_err++; $display("FAIL idle_quiet rises=%0d/%0d sen_n_high=%0d want 0/0/100", a_rises, b_rises, sn_hi);
    end
  endtask

  task automatic test_single();
    xfer("single", 0, 21'h15A5A5, 0, -1, '0);
  endtask

  task automatic test_fast();
    xfer("fast_81", 1, 21'h000081, 0, -1, '0);
  endtask

  task automatic test_back_to_back();
    repeat (3) step();
    xfer("b2b_first", 0, 21'h000001, 1, -1, '0);
    xfer("b2b_second", 0, 21'h1FFFFF, 0, -1, '0);
    n_cmp++;
    if (a_last_gap != 1) begin n_err++; $display("FAIL b2b_sen_gap got=%0d want=1", a_last_gap); end
  endtask

  task automatic test_busy();
    repeat (2) step();
    xfer("busy", 0, 21'h123456, 0, 50, 21'h0ABCDE);
    a_rises = 0;
    repeat (20) step();
    n_cmp++;
    if (a_rises != 0 || a_sen_n !== 1'b1) begin
      n_err++; $display("FAIL busy_no_ghost rises=%0d sen_n=%b want 0/1", a_rises, a_sen_n);
    end
  endtask

  task automatic test_reset_mid();
    a_data = 21'h1B2C3D; a_load = 1; a_rises = 0;
    @(posedge clk); #1; a_load = 0;
    for (int c = 0; c < 500 && a_rises < 10; c++) step();
    n_cmp++;
    if (a_rises != 10) begin n_err++; $display("FAIL reset_mid_reach got=%0d rises want=10", a_rises); end
    reset = 1; #1;
    n_cmp++;
    if ({a_ready, a_sen_n, a_sclk, a_sdo, a_done} !== 5'b11000) begin
      n_err++; $display("FAIL reset_mid_outputs got=%b want=11000", {a_ready, a_sen_n, a_sclk, a_sdo, a_done});
    end
    step(); reset = 0; step();
    xfer("after_reset", 0, 21'h054321, 0, -1, '0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 5)) step();
      xfer("rand_a", 0, 21'($urandom), 0, -1, '0);
      repeat ($urandom_range(0, 5)) step();
      xfer("rand_b", 1, 21'($urandom) & 21'hFF, 0, -1, '0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fast();
    test_back_to_back();
    test_busy();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
